// File: rtl/keypad_scanner_pkg.sv
// Shared constants for the 4x4 hex keypad scanner: matrix geometry and the
// fixed mapping from physical (row,col) position to CHIP-8 key value.
package keypad_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int NKEYS = ROWS * COLS;

  // Index is raw position 4*row+col; value is the CHIP-8 key it represents.
  localparam logic [3:0] KEY_MAP [0:NKEYS-1] = '{
    4'h1, 4'h2, 4'h3, 4'hC,
    4'h4, 4'h5, 4'h6, 4'hD,
    4'h7, 4'h8, 4'h9, 4'hE,
    4'hA, 4'h0, 4'hB, 4'hF
  };

  // Active-low one-hot row drive for row index r.
  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Pin-level bundle between the keypad scanner and the outside world.
// scan_done is a one-cycle strobe with no ready: the consumer samples it and
// keypad_matrix on the same cycle; there is no backpressure.
interface keypad_scanner_if;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] keypad_matrix;
  logic        scan_done;
  logic [1:0]  dbg_row;

  modport master (
    input  col_n,
    output row_n,
    output keypad_matrix,
    output scan_done,
    output dbg_row
  );

  modport slave (
    output col_n,
    input  row_n,
    input  keypad_matrix,
    input  scan_done,
    input  dbg_row
  );
endinterface

// File: rtl/keypad_scanner_key_debounce.sv
// Per-key frame debouncer: the output flips only after DEBOUNCE consecutive
// frames disagree with it; any agreeing frame restarts the count.
module key_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic raw,
  output logic state
);

  logic [3:0] cnt_q;
  logic       state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      state_q <= 1'b0;
    end else if (sample_en) begin
      if (raw == state_q) begin
        cnt_q <= 4'd0;
      end else if (cnt_q + 4'd1 == 4'(DEBOUNCE)) begin
        state_q <= ~state_q;
        cnt_q   <= 4'd0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates an active-low row drive, samples synchronised
// columns after a settle delay and debounces each key over whole frames.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES = 255,
  parameter int DEBOUNCE      = 4
) (
  input logic             clk,
  input logic             reset,
  keypad_scanner_if.master kp
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    col_s;
  logic [CW-1:0] settle_q;
  logic [1:0]    row_q;
  logic [3:0]    row_n_q;
  logic [11:0]   raw_q;
  logic          scan_done_q;
  logic          capture;
  logic          frame_en;
  logic [15:0]   frame;
  logic [15:0]   key_raw;
  logic [15:0]   matrix;

  assign col_s    = ~sync2_q;
  assign capture  = (settle_q == CW'(SETTLE_CYCLES));
  assign frame_en = capture && (row_q == 2'd3);
  // Row 3 is never stored: its columns go straight into the evaluated frame.
  assign frame    = {col_s, raw_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      settle_q    <= '0;
      row_q       <= 2'd0;
      row_n_q     <= 4'b1110;
      raw_q       <= 12'h000;
      scan_done_q <= 1'b0;
    end else begin
      sync1_q     <= kp.col_n;
      sync2_q     <= sync1_q;
      scan_done_q <= frame_en;
      if (capture) begin
        settle_q <= '0;
        row_q    <= row_q + 2'd1;
        row_n_q  <= row_drive(row_q + 2'd1);
        case (row_q)
          2'd0:    raw_q[3:0]  <= col_s;
          2'd1:    raw_q[7:4]  <= col_s;
          2'd2:    raw_q[11:8] <= col_s;
          default: ;
        endcase
      end else begin
        settle_q <= settle_q + CW'(1);
      end
    end
  end

  always_comb begin
    key_raw = 16'h0000;
    for (int p = 0; p < NKEYS; p++) begin
      key_raw[KEY_MAP[p]] = frame[p];
    end
  end

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk       (clk),
      .reset     (reset),
      .sample_en (frame_en),
      .raw       (key_raw[k]),
      .state     (matrix[k])
    );
  end

  assign kp.row_n         = row_n_q;
  assign kp.keypad_matrix = matrix;
  assign kp.scan_done     = scan_done_q;
  assign kp.dbg_row       = row_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a small keypad model that pulls a
// column low while its row is driven and the key at (row,col) is pressed.
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [15:0] pressed;  // bit 4*row+col
  logic [3:0]  col_model;
  int          total;
  int          bad;

  keypad_scanner_if kif ();

  keypad_scanner #(.SETTLE_CYCLES(7), .DEBOUNCE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    col_model = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!kif.row_n[r] && pressed[4*r+c]) col_model[c] = 1'b0;
      end
    end
  end
  assign kif.col_n = col_model;

  // Scoreboard-style check
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: wait for the next scan_done pulse, bounded.
  task automatic wait_scan(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!kif.scan_done && n < 200);
    check({tag, "_scan"}, {15'd0, kif.scan_done}, 16'h0001);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b0;
    pressed = 16'h0020;  // key (1,1) held from time 0
    #2 reset = 1'b1;
    #1;
    // 1: reset values appear immediately
    check("rst_row_n",  {12'd0, kif.row_n}, 16'h000E);
    check("rst_matrix", kif.keypad_matrix, 16'h0000);
    check("rst_done",   {15'd0, kif.scan_done}, 16'h0000);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 2: key 5 shows exactly on the 4th frame
    wait_scan("t2_f1"); check("t2_f1", kif.keypad_matrix, 16'h0000);
    wait_scan("t2_f2"); check("t2_f2", kif.keypad_matrix, 16'h0000);
    wait_scan("t2_f3"); check("t2_f3", kif.keypad_matrix, 16'h0000);
    wait_scan("t2_f4"); check("t2_f4", kif.keypad_matrix, 16'h0020);
    @(negedge clk);
    check("t2_pulse_len", {15'd0, kif.scan_done}, 16'h0000);

    // 5: release key 5, it clears on the 4th frame after release
    pressed = 16'h0000;
    wait_scan("t5_f1"); check("t5_f1", kif.keypad_matrix, 16'h0020);
    wait_scan("t5_f2"); check("t5_f2", kif.keypad_matrix, 16'h0020);
    wait_scan("t5_f3"); check("t5_f3", kif.keypad_matrix, 16'h0020);
    wait_scan("t5_f4"); check("t5_f4", kif.keypad_matrix, 16'h0000);

    // 3: bounce on key (0,0): press 2, release 1, press 2, release
    pressed = 16'h0001;
    wait_scan("t3_a"); check("t3_a", kif.keypad_matrix, 16'h0000);
    wait_scan("t3_b"); check("t3_b", kif.keypad_matrix, 16'h0000);
    pressed = 16'h0000;
    wait_scan("t3_c"); check("t3_c", kif.keypad_matrix, 16'h0000);
    pressed = 16'h0001;
    wait_scan("t3_d"); check("t3_d", kif.keypad_matrix, 16'h0000);
    wait_scan("t3_e"); check("t3_e", kif.keypad_matrix, 16'h0000);
    pressed = 16'h0000;
    wait_scan("t3_f"); check("t3_f", kif.keypad_matrix, 16'h0000);
    wait_scan("t3_g"); check("t3_g", kif.keypad_matrix, 16'h0000);

    // 4: keys (3,1) and (3,3) -> keys 0 and F; row rotation every 8 cycles
    pressed = 16'hA000;
    for (int r = 0; r < 4; r++) begin
      check($sformatf("t4_row%0d_first", r), {12'd0, kif.row_n}, {12'd0, ~(4'b0001 << r)});
      repeat (7) @(negedge clk);
      check($sformatf("t4_row%0d_last", r), {12'd0, kif.row_n}, {12'd0, ~(4'b0001 << r)});
      @(negedge clk);
    end
    check("t4_f1_scan", {15'd0, kif.scan_done}, 16'h0001);
    check("t4_f1", kif.keypad_matrix, 16'h0000);
    wait_scan("t4_f2"); check("t4_f2", kif.keypad_matrix, 16'h0000);
    wait_scan("t4_f3"); check("t4_f3", kif.keypad_matrix, 16'h0000);
    wait_scan("t4_f4"); check("t4_f4", kif.keypad_matrix, 16'h8001);

    // 6: reset mid-row-2 with key (2,3) held
    pressed = 16'h0800;
    wait_scan("t6_pre");
    repeat (19) @(negedge clk);
    check("t6_in_row2", {12'd0, kif.row_n}, 16'h000B);
    reset = 1'b1;
    #1;
    check("t6_rst_matrix", kif.keypad_matrix, 16'h0000);
    check("t6_rst_row_n",  {12'd0, kif.row_n}, 16'h000E);
    check("t6_rst_done",   {15'd0, kif.scan_done}, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_row0_after", {12'd0, kif.row_n}, 16'h000E);
    wait_scan("t6_f1"); check("t6_f1", kif.keypad_matrix, 16'h0000);
    wait_scan("t6_f2"); check("t6_f2", kif.keypad_matrix, 16'h0000);
    wait_scan("t6_f3"); check("t6_f3", kif.keypad_matrix, 16'h0000);
    wait_scan("t6_f4"); check("t6_f4", kif.keypad_matrix, 16'h4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
